// File: rtl/matrix_feeder.sv
// Host-side operand buffer and streamer for matrix_mult.
// Sends start, one gap cycle, A then B, then waits for done or times out.
module matrix_feeder #(
    parameter int DW      = 8,
    parameter int M       = 8,
    parameter int N       = 8,
    parameter int TIMEOUT = 1024,
    parameter int AW      = $clog2(2 * M * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          go,
    input  logic          mm_done,
    output logic          mm_start,
    output logic [DW-1:0] mm_data,
    output logic          mm_valid,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int TOTAL = 2 * M * N;
    localparam int IW    = $clog2(TOTAL + 1);
    localparam int CW    = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0] IDX_END  = IW'(TOTAL);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [CW-1:0] WAIT_END = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] ADDR0    = '0;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] GAP    = 3'd2;
    localparam logic [2:0] STREAM = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] wcnt;
    logic [DW-1:0] mem [TOTAL];

    // Buffer is not reset; the host must load it before the first go.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && int'(wr_addr) < TOTAL)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mm_start <= 1'b0;
            mm_valid <= 1'b0;
            mm_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            idx      <= '0;
            wcnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state    <= START;
                        mm_start <= 1'b1;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        idx      <= '0;
                        wcnt     <= '0;
                    end
                end
                START: begin
                    state    <= GAP;
                    mm_start <= 1'b0;
                end
                GAP: begin
                    state    <= STREAM;
                    mm_valid <= 1'b1;
                    mm_data  <= mem[ADDR0];
                    idx      <= IDX_ONE;
                end
                STREAM: begin
                    // idx names the element presented on the next cycle
                    if (idx == IDX_END) begin
                        state    <= WAIT;
                        mm_valid <= 1'b0;
                        mm_data  <= '0;
                    end else begin
                        mm_data <= mem[idx[AW-1:0]];
                        idx     <= idx + IDX_ONE;
                    end
                end
                WAIT: begin
                    if (mm_done) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else if (wcnt == WAIT_END) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        wcnt <= wcnt + CNT_ONE;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mm_start <= 1'b0;
                    mm_valid <= 1'b0;
                    mm_data  <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
